transaction_layer_ctrl: RTL and testbench

//  Main control FSM for the PCIe transaction layer: sequences the input FIFO and the four output FIFOs (P0..P3).

---
 rtl/transaction_layer_ctrl.sv | 130 +++++++++++++
 tb/tb_transaction_layer_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/transaction_layer_ctrl.sv
// Control FSM for the PCIe transaction layer. It captures the FIFO watermark thresholds during
// init, gates datapath flow, and records which FIFOs raised an error.
module transaction_layer_ctrl #(
  parameter int NUM_FIFOS  = 5,
  parameter int UMBRAL_W   = 3,
  parameter int UB_DEFAULT = 1,
  parameter int UA_DEFAULT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [UMBRAL_W-1:0]  Umbral_bajo_in,
  input  logic [UMBRAL_W-1:0]  Umbral_alto_in,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [NUM_FIFOS-1:0] fifo_error,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 active_out,
  output logic                 error_out,
  output logic [NUM_FIFOS-1:0] error_src,
  output logic [UMBRAL_W-1:0]  Umbral_bajo,
  output logic [UMBRAL_W-1:0]  Umbral_alto,
  output logic                 flow_en
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [UMBRAL_W-1:0] UB_RST = UMBRAL_W'(UB_DEFAULT);
  localparam logic [UMBRAL_W-1:0] UA_RST = UMBRAL_W'(UA_DEFAULT);

  state_t                 state_q, state_d;
  logic                   idle_q, idle_d;
  logic                   active_q, active_d;
  logic                   error_q, error_d;
  logic                   flow_en_q, flow_en_d;
  logic [NUM_FIFOS-1:0]   error_src_q, error_src_d;
  logic [UMBRAL_W-1:0]    ub_q, ub_d;
  logic [UMBRAL_W-1:0]    ua_q, ua_d;
  logic                   any_err;
  logic                   all_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RESET;
      idle_q      <= 1'b0;
      active_q    <= 1'b0;
      error_q     <= 1'b0;
      flow_en_q   <= 1'b0;
      error_src_q <= '0;
      ub_q        <= UB_RST;
      ua_q        <= UA_RST;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      active_q    <= active_d;
      error_q     <= error_d;
      flow_en_q   <= flow_en_d;
      error_src_q <= error_src_d;
      ub_q        <= ub_d;
      ua_q        <= ua_d;
    end
  end

  // Priority within each state: error, then init, then empty-based moves.
  always_comb begin
    state_d     = state_q;
    error_src_d = error_src_q;
    ub_d        = ub_q;
    ua_d        = ua_q;
    any_err     = |fifo_error;
    all_empty   = &fifo_empty;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (any_err) begin
          state_d     = ST_ERROR;
          error_src_d = error_src_q | fifo_error;
        end else if (init) begin
          ub_d = Umbral_bajo_in;
          ua_d = Umbral_alto_in;
        end else if (ub_q < ua_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (any_err) begin
          state_d     = ST_ERROR;
          error_src_d = error_src_q | fifo_error;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (!all_empty) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (any_err) begin
          state_d     = ST_ERROR;
          error_src_d = error_src_q | fifo_error;
        end else if (init) begin
          state_d = ST_INIT;
        end else if (all_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: error_src_d = error_src_q | fifo_error;
      default:  state_d = ST_RESET;
    endcase
    // Outputs are decoded from the next state so they update on the same edge as the state.
    idle_d    = (state_d == ST_IDLE);
    active_d  = (state_d == ST_ACTIVE);
    error_d   = (state_d == ST_ERROR);
    flow_en_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
  end

  assign state       = state_q;
  assign idle_out    = idle_q;
  assign active_out  = active_q;
  assign error_out   = error_q;
  assign flow_en     = flow_en_q;
  assign error_src   = error_src_q;
  assign Umbral_bajo = ub_q;
  assign Umbral_alto = ua_q;

endmodule

// File: tb/tb_transaction_layer_ctrl.sv
// Directed bench for transaction_layer_ctrl. Each scenario task drives its own stimulus and
// compares the outputs against hand-computed values.
module tb_transaction_layer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init = 1'b0;
  logic [2:0] Umbral_bajo_in = '0;
  logic [2:0] Umbral_alto_in = '0;
  logic [4:0] fifo_empty = 5'b11111;
  logic [4:0] fifo_error = '0;
  logic [2:0] state;
  logic       idle_out, active_out, error_out, flow_en;
  logic [4:0] error_src;
  logic [2:0] Umbral_bajo, Umbral_alto;

  int checks = 0;
  int errors = 0;

  transaction_layer_ctrl dut (
    .clk(clk), .reset(reset), .init(init),
    .Umbral_bajo_in(Umbral_bajo_in), .Umbral_alto_in(Umbral_alto_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .state(state), .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
    .error_src(error_src), .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
    .flow_en(flow_en)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // Advance one edge, then sit 1 time unit past it before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; fifo_empty = 5'b11111; fifo_error = '0;
    step();
    reset = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({idle_out, active_out, error_out, flow_en} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {idle_out, active_out, error_out, flow_en}); end
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd1, 3'd6}) begin errors++; $display("FAIL rst_umbral got=%0d/%0d exp=1/6", Umbral_bajo, Umbral_alto); end
    checks++; if (error_src !== 5'b0) begin errors++; $display("FAIL rst_src got=%b exp=00000", error_src); end
    step();
    checks++; if (state !== 3'd1 || flow_en !== 1'b0) begin errors++; $display("FAIL rst_to_init got=%0d/%b exp=1/0", state, flow_en); end
    step();
    checks++; if (state !== 3'd2 || idle_out !== 1'b1 || flow_en !== 1'b1) begin errors++; $display("FAIL init_to_idle got=%0d/%b/%b exp=2/1/1", state, idle_out, flow_en); end
  endtask

  task automatic test_reconfig();
    init = 1'b1; Umbral_bajo_in = 3'd2; Umbral_alto_in = 3'd5;
    step();
    checks++; if (state !== 3'd1 || flow_en !== 1'b0 || idle_out !== 1'b0) begin errors++; $display("FAIL idle_to_init got=%0d/%b/%b exp=1/0/0", state, flow_en, idle_out); end
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd1, 3'd6}) begin errors++; $display("FAIL no_sample_on_entry got=%0d/%0d exp=1/6", Umbral_bajo, Umbral_alto); end
    step();
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd2, 3'd5}) begin errors++; $display("FAIL load_2_5 got=%0d/%0d exp=2/5", Umbral_bajo, Umbral_alto); end
    init = 1'b0;
    step();
    checks++; if (state !== 3'd2 || flow_en !== 1'b1) begin errors++; $display("FAIL reconfig_idle got=%0d/%b exp=2/1", state, flow_en); end
  endtask

  task automatic test_invalid_thresholds();
    init = 1'b1; Umbral_bajo_in = 3'd5; Umbral_alto_in = 3'd3;
    step();
    step();
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd5, 3'd3}) begin errors++; $display("FAIL load_5_3 got=%0d/%0d exp=5/3", Umbral_bajo, Umbral_alto); end
    init = 1'b0;
    step();
    step();
    checks++; if (state !== 3'd1 || flow_en !== 1'b0) begin errors++; $display("FAIL invalid_stays_init got=%0d/%b exp=1/0", state, flow_en); end
    init = 1'b1; Umbral_bajo_in = 3'd4; Umbral_alto_in = 3'd4;
    step();
    init = 1'b0;
    step();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL equal_stays_init got=%0d exp=1", state); end
    init = 1'b1; Umbral_bajo_in = 3'd1; Umbral_alto_in = 3'd4;
    step();
    init = 1'b0;
    step();
    checks++; if (state !== 3'd2 || flow_en !== 1'b1 || {Umbral_bajo, Umbral_alto} !== {3'd1, 3'd4}) begin errors++; $display("FAIL reload_1_4 got=%0d/%b/%0d/%0d exp=2/1/1/4", state, flow_en, Umbral_bajo, Umbral_alto); end
  endtask

  task automatic test_empty_flow();
    fifo_empty = 5'b11101;
    step();
    checks++; if (state !== 3'd3 || active_out !== 1'b1 || idle_out !== 1'b0 || flow_en !== 1'b1) begin errors++; $display("FAIL to_active got=%0d/%b/%b/%b exp=3/1/0/1", state, active_out, idle_out, flow_en); end
    fifo_empty = 5'b11111;
    step();
    checks++; if (state !== 3'd2 || idle_out !== 1'b1 || active_out !== 1'b0) begin errors++; $display("FAIL to_idle got=%0d/%b/%b exp=2/1/0", state, idle_out, active_out); end
    fifo_empty = 5'b11101;
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL re_active got=%0d exp=3", state); end
  endtask

  task automatic test_error();
    fifo_error = 5'b00100; init = 1'b1; Umbral_bajo_in = 3'd0; Umbral_alto_in = 3'd7;
    step();
    checks++; if (state !== 3'd4 || error_out !== 1'b1 || flow_en !== 1'b0 || active_out !== 1'b0) begin errors++; $display("FAIL error_beats_init got=%0d/%b/%b/%b exp=4/1/0/0", state, error_out, flow_en, active_out); end
    checks++; if (error_src !== 5'b00100) begin errors++; $display("FAIL src_first got=%b exp=00100", error_src); end
    fifo_error = 5'b00001;
    step();
    checks++; if (error_src !== 5'b00101 || state !== 3'd4) begin errors++; $display("FAIL src_accum got=%b/%0d exp=00101/4", error_src, state); end
    fifo_error = '0; fifo_empty = 5'b11111;
    step();
    step();
    checks++; if (state !== 3'd4 || error_src !== 5'b00101) begin errors++; $display("FAIL error_sticky got=%0d/%b exp=4/00101", state, error_src); end
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd1, 3'd4}) begin errors++; $display("FAIL umbral_frozen got=%0d/%0d exp=1/4", Umbral_bajo, Umbral_alto); end
    init = 1'b0;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    fifo_empty = 5'b11110;
    step();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pre_reset_active got=%0d exp=3", state); end
    #2 reset = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || {idle_out, active_out, error_out, flow_en} !== 4'b0000 || error_src !== 5'b0) begin errors++; $display("FAIL async_clear got=%0d/%b/%b exp=0/0000/00000", state, {idle_out, active_out, error_out, flow_en}, error_src); end
    checks++; if ({Umbral_bajo, Umbral_alto} !== {3'd1, 3'd6}) begin errors++; $display("FAIL async_umbral got=%0d/%0d exp=1/6", Umbral_bajo, Umbral_alto); end
    #2 reset = 1'b0;
    fifo_empty = 5'b11111; fifo_error = 5'b11111;
    step();
    checks++; if (state !== 3'd1 || error_out !== 1'b0 || error_src !== 5'b0) begin errors++; $display("FAIL err_ignored_in_reset got=%0d/%b/%b exp=1/0/00000", state, error_out, error_src); end
    fifo_error = '0;
    step();
    checks++; if (state !== 3'd2 || flow_en !== 1'b1) begin errors++; $display("FAIL rerun_idle got=%0d/%b exp=2/1", state, flow_en); end
    fifo_error = 5'b00010; init = 1'b1;
    step();
    checks++; if (state !== 3'd4 || error_src !== 5'b00010) begin errors++; $display("FAIL idle_error got=%0d/%b exp=4/00010", state, error_src); end
    fifo_error = '0; init = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_invalid_thresholds();
    test_empty_flow();
    test_error();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
